mem_loader: RTL and testbench

- Data-fetch stage directly downstream of the accelerator control FSM.
- When control raises read_enable, the block accepts a word stream from the external input port (valid/ready).
- Words are written sequentially into either the weight buffer or the image buffer, as selected by img_weight_sel.
- Returns a one-cycle finish_read pulse once the selected buffer is full; control uses it to advance to IDLE or CONV.

---
 rtl/data_types_pkg.sv | 31 +++
 rtl/loader_addr_counter.sv | 53 +++++
 rtl/mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_mem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_types_pkg.sv
// Shared types and constants for the accelerator datapath.
// Contents:
//   img_weights_sel_t - target buffer select (SEL_IMG / SEL_WEIGHTS)
//   LOADER_STATE_t    - mem_loader FSM states. The _L suffix keeps these
//                       names distinct from the control FSM's own enum.
//   IMG_WORDS_C, WEIGHT_WORDS_C - default load sizes (28x28 frame, 3x3 kernel)
//   csum_add()        - modulo-2^16 accumulate helper for the load checksum
package data_types_pkg;

  typedef enum logic {
    SEL_IMG     = 1'b0,
    SEL_WEIGHTS = 1'b1
  } img_weights_sel_t;

  typedef enum logic [1:0] {
    IDLE_L     = 2'd0,
    LOAD_L     = 2'd1,
    DONE_L     = 2'd2,
    WAIT_REL_L = 2'd3
  } LOADER_STATE_t;

  localparam int IMG_WORDS_C    = 784;
  localparam int WEIGHT_WORDS_C = 9;

  // Modulo-2^16 add; the carry out of bit 15 is intentionally discarded.
  function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                           input logic [15:0] word);
    csum_add = acc + word;
  endfunction

endpackage

// File: rtl/loader_addr_counter.sv
// Write-address counter for mem_loader.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - force count to 0 (load start or abort)
//   inc       - one accepted word this cycle
//   limit     - number of words in the current load
//   count     - address of the next word to be written
//   is_last   - count addresses the final word of the load
// The counter returns to 0 after the last word, so it never exceeds limit-1.
module loader_addr_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] count,
  output logic              is_last
);

  logic [ADDR_W-1:0] count_d;
  logic [ADDR_W-1:0] count_q;

  assign count   = count_q;
  assign is_last = (count_q == (limit - ADDR_W'(1)));

  // Next-count decode: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (is_last) begin
        count_d = '0;
      end else begin
        count_d = count_q + ADDR_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: data-fetch stage behind the accelerator control FSM.
// While read_enable is high it accepts a valid/ready word stream and writes
// the words sequentially into the weight or image buffer (chosen by
// img_weight_sel when the load starts), then pulses finish_read once.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   read_enable         - level load request from control
//   img_weight_sel      - target buffer, sampled only when a load starts
//   in_valid/in_data    - input stream
//   in_ready            - stream accept (registered)
//   wgt_we/img_we       - buffer write strobes
//   buf_addr/buf_data   - shared write address/data
//   finish_read         - one-cycle pulse after the last write
//   load_busy           - high in LOAD
//   load_checksum       - modulo-2^16 sum of accepted words
//                         (only when MEM_LOADER_CHECKSUM_EN is defined)
// All outputs are registered.
module mem_loader
  import data_types_pkg::*;
#(
  parameter  int DATA_W       = 8,
  parameter  int IMG_WORDS    = IMG_WORDS_C,
  parameter  int WEIGHT_WORDS = WEIGHT_WORDS_C,
  localparam int ADDR_W       = $clog2(IMG_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_enable,
  input  img_weights_sel_t img_weight_sel,
  input  logic             in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic             in_ready,
  output logic             wgt_we,
  output logic             img_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic             finish_read,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [15:0]      load_checksum,
`endif
  output logic             load_busy
);

  LOADER_STATE_t    state_d, state_q;
  img_weights_sel_t sel_d, sel_q;
  logic [ADDR_W-1:0] limit_d, limit_q;
  logic              in_ready_d, in_ready_q;
  logic              load_busy_d, load_busy_q;
  logic              wgt_we_d, wgt_we_q;
  logic              img_we_d, img_we_q;
  logic [ADDR_W-1:0] buf_addr_d, buf_addr_q;
  logic [DATA_W-1:0] buf_data_d, buf_data_q;
  logic              finish_read_d, finish_read_q;

  logic              handshake_s;
  logic              start_s;
  logic              cnt_clr_s;
  logic [ADDR_W-1:0] count_s;
  logic              is_last_s;

  // in_ready_q is only ever set while in LOAD, but gate on the state anyway
  // so an accept can never be seen outside a load.
  assign handshake_s = (state_q == LOAD_L) & in_valid & in_ready_q;

  loader_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr_s),
    .inc     (handshake_s),
    .limit   (limit_q),
    .count   (count_s),
    .is_last (is_last_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    limit_d    = limit_q;
    wgt_we_d   = 1'b0;
    img_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    start_s    = 1'b0;
    cnt_clr_s  = 1'b0;

    case (state_q)
      IDLE_L: begin
        if (read_enable) begin
          sel_d     = img_weight_sel;
          limit_d   = (img_weight_sel == SEL_WEIGHTS) ? ADDR_W'(WEIGHT_WORDS)
                                                      : ADDR_W'(IMG_WORDS);
          start_s   = 1'b1;
          cnt_clr_s = 1'b1;
          state_d   = LOAD_L;
        end else begin
          state_d = IDLE_L;
        end
      end
      LOAD_L: begin
        // A word accepted in this cycle is written even if the load is
        // aborted in the same cycle: the source already saw it consumed.
        if (handshake_s) begin
          wgt_we_d   = (sel_q == SEL_WEIGHTS);
          img_we_d   = (sel_q == SEL_IMG);
          buf_addr_d = count_s;
          buf_data_d = in_data;
        end else begin
          wgt_we_d = 1'b0;
          img_we_d = 1'b0;
        end
        if (!read_enable) begin
          cnt_clr_s = 1'b1;
          state_d   = IDLE_L;
        end else if (handshake_s && is_last_s) begin
          state_d = DONE_L;
        end else begin
          state_d = LOAD_L;
        end
      end
      DONE_L: begin
        state_d = WAIT_REL_L;
      end
      WAIT_REL_L: begin
        // Wait out control's lagging read_enable so it cannot restart a load.
        if (!read_enable) begin
          state_d = IDLE_L;
        end else begin
          state_d = WAIT_REL_L;
        end
      end
      default: begin
        state_d = IDLE_L;
      end
    endcase

    // Registered outputs follow the next state, so in_ready drops in the
    // same update that leaves LOAD and no extra word is taken.
    in_ready_d    = (state_d == LOAD_L);
    load_busy_d   = (state_d == LOAD_L);
    finish_read_d = (state_q == DONE_L);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE_L;
      sel_q         <= SEL_IMG;
      limit_q       <= ADDR_W'(IMG_WORDS);
      in_ready_q    <= 1'b0;
      load_busy_q   <= 1'b0;
      wgt_we_q      <= 1'b0;
      img_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      finish_read_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      limit_q       <= limit_d;
      in_ready_q    <= in_ready_d;
      load_busy_q   <= load_busy_d;
      wgt_we_q      <= wgt_we_d;
      img_we_q      <= img_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      finish_read_q <= finish_read_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign load_busy   = load_busy_q;
  assign wgt_we      = wgt_we_q;
  assign img_we      = img_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_data    = buf_data_q;
  assign finish_read = finish_read_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] csum_d, csum_q;

  // Checksum accumulate; holds its value after the load until the next start.
  always_comb begin
    csum_d = csum_q;
    if (start_s) begin
      csum_d = 16'h0000;
    end else if (handshake_s) begin
      csum_d = csum_add(csum_q, 16'(in_data));
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= 16'h0000;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign load_checksum = csum_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of load scenarios, randomized
// loads, plus hand-written abort and async-reset sequences.
module tb_mem_loader;
  import data_types_pkg::*;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 784;
  localparam int WGT_W  = 9;
  localparam int ADDR_W = $clog2(IMG_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              read_enable;
  img_weights_sel_t  img_weight_sel;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wgt_we;
  logic              img_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              finish_read;
  logic              load_busy;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0]       load_checksum;
`endif

  mem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .read_enable    (read_enable),
    .img_weight_sel (img_weight_sel),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .wgt_we         (wgt_we),
    .img_we         (img_we),
    .buf_addr       (buf_addr),
    .buf_data       (buf_data),
    .finish_read    (finish_read),
`ifdef MEM_LOADER_CHECKSUM_EN
    .load_checksum  (load_checksum),
`endif
    .load_busy      (load_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        wgt_log[$];
  wr_t        img_log[$];
  logic [7:0] sent_q[$];
  int         fin_cnt = 0;
  int         fin_cyc = -1;
  int         overlap = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (wgt_we === 1'b1) wgt_log.push_back('{int'(buf_addr), int'(buf_data), cyc});
    if (img_we === 1'b1) img_log.push_back('{int'(buf_addr), int'(buf_data), cyc});
    if (finish_read === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
      if (wgt_we === 1'b1 || img_we === 1'b1) overlap++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_logs();
    wgt_log.delete();
    img_log.delete();
    fin_cnt = 0;
    fin_cyc = -1;
    overlap = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One complete load: start, stream all words with random gaps, over-supply
  // with read_enable held for 'hold' extra cycles, release, then check the
  // writes against the words the bench offered.
  task automatic run_load(input string tag, input img_weights_sel_t sel, input int gap,
                          input bit rnd, input bit flip, input int hold,
                          input int exp_wgt, input int exp_img, input int exp_fin);
    int n, acc, budget, bad_rdy, bad_post, bad_wr, last_cyc;
    int sum;
    wr_t tgt[$];
    n = (sel == SEL_WEIGHTS) ? WGT_W : IMG_W;
    clear_logs();
    sent_q.delete();
    acc = 0; bad_rdy = 0; bad_post = 0; bad_wr = 0;
    budget = n * 50 + 100;
    img_weight_sel = sel;
    read_enable = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    tick(1);
    while (acc < n && budget > 0) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = rnd ? 8'($urandom) : 8'(acc + 1);
      if (flip) img_weight_sel = (img_weight_sel == SEL_IMG) ? SEL_WEIGHTS : SEL_IMG;
      @(negedge clk);
      if (in_ready !== 1'b1) bad_rdy++;
      if (in_valid) begin
        sent_q.push_back(in_data);
        acc++;
      end
      tick(1);
      budget--;
    end
    chk({tag, "_budget"}, acc, n);
    chk({tag, "_in_ready_during_load"}, bad_rdy, 0);
    // Over-supply while control lags on read_enable: nothing more accepted.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int k = 0; k < hold + 3; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || load_busy !== 1'b0) bad_post++;
      tick(1);
    end
    chk({tag, "_no_accept_after_last"}, bad_post, 0);
    read_enable = 1'b0;
    in_valid = 1'b0;
    tick(2);
    chk({tag, "_idle_after_release"}, {30'd0, in_ready, load_busy}, 32'd0);
    chk({tag, "_wgt_writes"}, wgt_log.size(), exp_wgt);
    chk({tag, "_img_writes"}, img_log.size(), exp_img);
    chk({tag, "_finish_pulses"}, fin_cnt, exp_fin);
    chk({tag, "_we_finish_overlap"}, overlap, 0);
    tgt = (sel == SEL_WEIGHTS) ? wgt_log : img_log;
    for (int i = 0; i < tgt.size() && i < sent_q.size(); i++) begin
      if (tgt[i].addr != i || tgt[i].data != int'(sent_q[i])) bad_wr++;
    end
    chk({tag, "_addr_data_seq"}, bad_wr, 0);
    last_cyc = (tgt.size() > 0) ? tgt[tgt.size() - 1].cyc : -100;
    chk({tag, "_finish_after_last_write"}, fin_cyc, last_cyc + 1);
    sum = 0;
    foreach (sent_q[i]) sum += int'(sent_q[i]);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, load_checksum, sum & 16'hFFFF);
`endif
  endtask

  typedef struct {
    string            tag;
    img_weights_sel_t sel;
    int               gap;
    bit               rnd;
    bit               flip;
    int               hold;
    int               exp_wgt;
    int               exp_img;
    int               exp_fin;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    vecs[0] = '{"wgt_seq",     SEL_WEIGHTS, 0,  1'b0, 1'b0, 0, 9, 0,   1};
    vecs[1] = '{"img_gaps",    SEL_IMG,     30, 1'b1, 1'b0, 0, 0, 784, 1};
    vecs[2] = '{"lag_release", SEL_WEIGHTS, 0,  1'b1, 1'b0, 3, 9, 0,   1};
    vecs[3] = '{"sel_toggle",  SEL_WEIGHTS, 20, 1'b1, 1'b1, 0, 9, 0,   1};
    vecs[4] = '{"img_b2b",     SEL_IMG,     0,  1'b1, 1'b0, 1, 0, 784, 1};

    rst = 1'b0;
    read_enable = 1'b0;
    img_weight_sel = SEL_IMG;
    in_valid = 1'b0;
    in_data = 8'h00;
    #3;
    chk("reset_ctrl", {27'd0, in_ready, load_busy, wgt_we, img_we, finish_read}, 32'd0);
    chk("reset_addr", buf_addr, 0);
    chk("reset_data", buf_data, 0);
    #9 rst = 1'b1;
    tick(2);
    chk("idle_no_request", {30'd0, in_ready, load_busy}, 32'd0);

    // Table of scenarios.
    for (int v = 0; v < 5; v++) begin
      run_load(vecs[v].tag, vecs[v].sel, vecs[v].gap, vecs[v].rnd, vecs[v].flip,
               vecs[v].hold, vecs[v].exp_wgt, vecs[v].exp_img, vecs[v].exp_fin);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    run_load("wgt_csum", SEL_WEIGHTS, 0, 1'b0, 1'b0, 0, 9, 0, 1);
    chk("wgt_csum_const", load_checksum, 16'h002D);
`endif

    // Randomized loads.
    for (int r = 0; r < 4; r++) begin
      img_weights_sel_t s;
      s = ($urandom_range(1) == 1) ? SEL_WEIGHTS : SEL_IMG;
      run_load($sformatf("rand%0d", r), s, int'($urandom_range(50)), 1'b1, 1'b0,
               int'($urandom_range(3)), (s == SEL_WEIGHTS) ? 9 : 0,
               (s == SEL_IMG) ? 784 : 0, 1);
    end

    // Abort after 4 of 9 weight words.
    clear_logs();
    img_weight_sel = SEL_WEIGHTS;
    read_enable = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h40 + i);
      tick(1);
    end
    in_valid = 1'b0;
    read_enable = 1'b0;
    tick(1);
    chk("abort_idle_next", {30'd0, in_ready, load_busy}, 32'd0);
    tick(3);
    chk("abort_writes", wgt_log.size(), 4);
    chk("abort_no_finish", fin_cnt, 0);
    bad = 0;
    for (int i = 0; i < wgt_log.size(); i++) begin
      if (wgt_log[i].addr != i || wgt_log[i].data != 8'h40 + i) bad++;
    end
    chk("abort_partial_seq", bad, 0);
    run_load("after_abort", SEL_WEIGHTS, 10, 1'b1, 1'b0, 0, 9, 0, 1);

    // Async reset mid image load, between clock edges.
    clear_logs();
    img_weight_sel = SEL_IMG;
    read_enable = 1'b1;
    tick(1);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      tick(1);
    end
    chk("pre_reset_loading", {30'd0, load_busy, img_we}, 32'd3);
    #2 rst = 1'b0;
    read_enable = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_reset_ctrl", {27'd0, in_ready, load_busy, wgt_we, img_we, finish_read}, 32'd0);
    chk("async_reset_addr", buf_addr, 0);
    chk("async_reset_data", buf_data, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    run_load("after_reset", SEL_IMG, 25, 1'b1, 1'b0, 0, 0, 784, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
